// File: rtl/light_pkg.sv
// Shared constants and types for the traffic-light display: legal lamp patterns,
// fault-tracking states and the two non-digit segment codes.
package light_pkg;

  localparam logic [5:0] GREEN  = 6'b001100;
  localparam logic [5:0] YELLOW = 6'b010010;
  localparam logic [5:0] RED    = 6'b100001;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    SUSPECT = 2'd1,
    FAULT   = 2'd2,
    RECOVER = 2'd3
  } fault_state_t;

  function automatic logic is_legal(input logic [5:0] p);
    return (p == GREEN) || (p == YELLOW) || (p == RED);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment pattern (bit0=a .. bit6=g); purely combinational,
// no flow control. Codes 10-15 show blank.
module seg7_decode
  import light_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/light_display.sv
// Controller-to-pins display stage: two-digit multiplexed countdown, blinking lamps, fault safe mode.
// Input to lamp/fault: 2 cycles; digits refresh on scan ticks; no backpressure (always accepts).
module light_display
  import light_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 25000000,
  parameter int FAULT_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] countdown_time,
  input  logic [5:0] led_light,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [5:0] lamp,
  output logic       fault
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  localparam int CW = $clog2(FAULT_CYC + 1);

  logic [4:0]    cd_q;
  logic [5:0]    led_q;
  logic          yel_prev;
  fault_state_t  state;
  logic [CW-1:0] cnt;
  logic          blink;
  logic [BW-1:0] blink_cnt;
  logic [SW-1:0] scan_cnt;
  logic          digit_sel;

  logic          legal;
  logic          is_yel;
  logic          yel_start;
  logic          cnt_done;
  logic          enter_fault;
  logic          blink_nxt;
  logic [BW-1:0] blink_cnt_nxt;
  logic [5:0]    lamp_legal;
  logic [5:0]    lamp_flash;
  logic          scan_tick;
  logic          show_dash;
  logic [3:0]    tens;
  logic [4:0]    tens_x10;
  logic [3:0]    units;
  logic [6:0]    tens_seg;
  logic [6:0]    units_seg;
  logic [6:0]    tens_shown;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_q     <= '0;
      led_q    <= '0;
      yel_prev <= 1'b0;
    end else begin
      cd_q     <= countdown_time;
      led_q    <= led_light;
      yel_prev <= is_yel;
    end
  end

  assign legal       = is_legal(led_q);
  assign is_yel      = (led_q == YELLOW);
  assign yel_start   = is_yel && !yel_prev;
  assign cnt_done    = (int'(cnt) + 1 >= FAULT_CYC);
  assign enter_fault = !legal && ((state == SUSPECT && cnt_done) || state == RECOVER);

  // Phase restarts so a fresh yellow or a fresh fault always begins with lamps lit.
  always_comb begin
    blink_nxt     = blink;
    blink_cnt_nxt = blink_cnt + BW'(1);
    if (yel_start || enter_fault) begin
      blink_nxt     = 1'b1;
      blink_cnt_nxt = '0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_nxt     = ~blink;
      blink_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else begin
      blink     <= blink_nxt;
      blink_cnt <= blink_cnt_nxt;
    end
  end

  assign lamp_legal = is_yel ? (led_q & {6{blink_nxt}}) : led_q;
  assign lamp_flash = YELLOW & {6{blink_nxt}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= NORMAL;
      cnt   <= '0;
      fault <= 1'b0;
      lamp  <= '0;
    end else begin
      case (state)
        NORMAL: begin
          if (!legal) begin
            state <= SUSPECT;
            cnt   <= CW'(1);
          end else begin
            lamp <= lamp_legal;
          end
        end
        SUSPECT: begin
          if (legal) begin
            state <= NORMAL;
            cnt   <= '0;
            lamp  <= lamp_legal;
          end else if (cnt_done) begin
            state <= FAULT;
            cnt   <= CW'(FAULT_CYC);
            fault <= 1'b1;
            lamp  <= lamp_flash;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FAULT: begin
          lamp <= lamp_flash;
          if (legal) begin
            state <= RECOVER;
            cnt   <= CW'(1);
          end
        end
        RECOVER: begin
          if (!legal) begin
            state <= FAULT;
            cnt   <= CW'(FAULT_CYC);
            lamp  <= lamp_flash;
          end else if (cnt_done) begin
            state <= NORMAL;
            cnt   <= '0;
            fault <= 1'b0;
            lamp  <= lamp_legal;
          end else begin
            cnt  <= cnt + CW'(1);
            lamp <= lamp_flash;
          end
        end
        default: state <= NORMAL;
      endcase
    end
  end

  always_comb begin
    tens     = 4'd0;
    tens_x10 = 5'd0;
    if (cd_q >= 5'd30) begin
      tens     = 4'd3;
      tens_x10 = 5'd30;
    end else if (cd_q >= 5'd20) begin
      tens     = 4'd2;
      tens_x10 = 5'd20;
    end else if (cd_q >= 5'd10) begin
      tens     = 4'd1;
      tens_x10 = 5'd10;
    end
  end

  assign units = 4'(cd_q - tens_x10);

  seg7_decode u_tens (.bcd(tens),  .seg(tens_seg));
  seg7_decode u_units(.bcd(units), .seg(units_seg));

  assign tens_shown = (tens == 4'd0) ? SEG_BLANK : tens_seg;
  assign show_dash  = (state == FAULT) || (state == RECOVER);
  assign scan_tick  = (scan_cnt == SW'(SCAN_DIV - 1));

  // Each tick loads the digit being switched to, so an/seg always agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_sel <= 1'b0;
      an        <= 2'b11;
      seg       <= SEG_BLANK;
    end else if (scan_tick) begin
      scan_cnt  <= '0;
      digit_sel <= ~digit_sel;
      if (!digit_sel) begin
        an  <= 2'b01;
        seg <= show_dash ? SEG_DASH : tens_shown;
      end else begin
        an  <= 2'b10;
        seg <= show_dash ? SEG_DASH : units_seg;
      end
    end else begin
      scan_cnt <= scan_cnt + SW'(1);
    end
  end

endmodule

// File: doc/light_display.md
# light_display

Display-side consumer of the traffic controller's outputs. It samples `countdown_time` and `led_light` and drives a two-digit multiplexed seven-segment display and the six lamp outputs. Yellow lamps blink. Any light pattern that is not a legal controller state is flagged as a fault, and in fault the display falls back to a flashing-yellow safe mode. It sits between the controller and the board pins, in the same single clock domain.

## Interface
- `SCAN_DIV`, default 50000: clk cycles per digit-scan tick; minimum 2.
- `BLINK_DIV`, default 25000000: clk cycles per blink half-period; minimum 2.
- `FAULT_CYC`, default 4: consecutive cycles an illegal or legal pattern must persist to enter or leave fault; minimum 1.
- `clk`, in, 1: system clock. One clock domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `countdown_time`, in, 5: remaining seconds, binary 0–31.
- `led_light`, in, 6: controller lamp pattern.
- `seg`, out, 7: segments, active-low; bit0=a … bit6=g.
- `an`, out, 2: digit enables, active-low; an[0]=units, an[1]=tens.
- `lamp`, out, 6: lamp drive, active-high, same bit order as `led_light`.
- `fault`, out, 1: high while in FAULT or RECOVER.

## Operation
- Input stage: `countdown_time` and `led_light` are registered every cycle into `cd_q` and `led_q`. All further logic uses only `cd_q` and `led_q`.
- Legal patterns:
  - GREEN = 6'b001100
  - YELLOW = 6'b010010
  - RED = 6'b100001
  - Every other value is illegal.
- Fault FSM states are NORMAL, SUSPECT, FAULT and RECOVER; `cnt` is a saturating counter.
  - NORMAL: on an illegal `led_q`, go to SUSPECT with cnt=1.
  - SUSPECT: while illegal, cnt++; at cnt==FAULT_CYC go to FAULT. On a legal pattern, go back to NORMAL.
  - FAULT: on a legal `led_q`, go to RECOVER with cnt=1.
  - RECOVER: while legal, cnt++; at cnt==FAULT_CYC go to NORMAL. On an illegal pattern, go back to FAULT.
  - If FAULT_CYC=1, SUSPECT→FAULT on its first illegal cycle.
- BCD conversion:
  - tens = 3 if cd_q≥30, 2 if ≥20, 1 if ≥10, else 0.
  - units = cd_q − 10·tens.
  - No division logic.
- Leading-zero blanking: if tens==0, the tens digit shows blank (seg=7'h7F). The units digit always shows, so 0 displays as "0".
- In FAULT or RECOVER, both digits show "-" (only segment g lit: seg=7'b0111111).
- Lamp output:
  - NORMAL or SUSPECT with GREEN or RED: `lamp` = `led_q`.
  - YELLOW: `lamp` = `led_q` & {6{blink}}.
  - SUSPECT with an illegal pattern: `lamp` holds its last legal output.
  - FAULT or RECOVER: `lamp` = 6'b010010 & {6{blink}}.
- Blink generator: a free-running counter toggles `blink` every BLINK_DIV cycles. It is forced to 1 and the counter cleared on:
  - the first cycle a YELLOW pattern is seen after a non-YELLOW pattern, and
  - entry to FAULT.
- Scan: a tick every SCAN_DIV cycles toggles `digit_sel`. On each tick `an`/`seg` load the newly selected digit, so the two digits alternate.

## Timing
- Reset values:
  - `seg`=7'h7F, `an`=2'b11, `lamp`=6'b000000, `fault`=0.
  - FSM=NORMAL, `blink`=1, `digit_sel`=0, all counters 0, `cd_q`=0, `led_q`=0.
- The first scan tick occurs SCAN_DIV cycles after reset release; `an` stays 2'b11 until then.
- Latency:
  - Input change → `lamp`/FSM: 2 cycles (input register plus output register).
  - Input change → `seg`: at the next scan tick after `cd_q` updates, for the digit then being scanned.
- `fault` is registered and rises FAULT_CYC+1 cycles after the first illegal input cycle.
- `lamp` output is 6'b000000 after reset until the first legal pattern is seen. The reset value 6'b000000 is itself illegal, so a bench must drive a legal pattern before `rst_n` rises or FAULT follows.
- Simultaneous scan tick and blink toggle are independent; both take effect that cycle.
- Counter wrap: scan and blink counters reload to 0 at DIV−1; `cnt` saturates at FAULT_CYC.
- Reset asserted mid-operation clears everything immediately (asynchronous). Outputs take their reset values in the same instant.

## Structure
- Package `light_pkg` holds:
  - the GREEN/YELLOW/RED pattern constants,
  - the fault-state enum (2 bits),
  - the SEG_BLANK and SEG_DASH constants.
- Sub-module `seg7_decode`: combinational 4-bit BCD → active-low 7-segment. Codes 10–15 output SEG_BLANK.
- Everything else (input regs, FSM, blink, scan, BCD split) lives in `light_display`.

## Test plan
- **Normal green countdown.** Input countdown 16, GREEN, SCAN_DIV=4.
  - an alternates 2'b10/2'b01.
  - Units seg=7'b0000010 ("6"), tens seg=7'b1111001 ("1").
  - lamp=6'b001100, fault=0.
- **Yellow blink and zero blanking.** Input YELLOW, countdown 5, BLINK_DIV=8.
  - lamp=6'b010010 for 8 cycles, then 6'b000000 for 8 cycles, repeating.
  - Tens digit blank (7'h7F); units shows "5".
- **Fault entry.** Hold led_light=6'b111111 with FAULT_CYC=4.
  - fault rises 5 cycles after the input changes.
  - Both digits show 7'b0111111.
  - lamp flashes 6'b010010.
- **Glitch rejection and recovery.**
  - An illegal pattern held 3 cycles, then RED: no fault; lamp holds the prior legal value during the glitch, then shows 6'b100001.
  - From FAULT, RED held 4 cycles: fault falls; lamp=6'b100001.
- **Boundary BCD.** countdown 31 → "31"; 10 → "10"; 0 → blank/"0"; 9 → blank/"9".
- **Async reset mid-scan.** Pulse rst_n low for half a cycle at an arbitrary point.
  - Outputs immediately show seg=7'h7F, an=2'b11, lamp=0, fault=0.
  - The scan restarts from digit 0 after reset release.
